// File: rtl/param_flasher_pkg.sv
// Shared definitions for the lamp flasher: state codes and the level-width helper.
package param_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } state_t;

    // Ceiling log2; clog2(MX_LP+1) is the width needed to hold levels 0..MX_LP.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_flasher_tick_gen.sv
// Step divider: tick fires on the last count of each DIV-clock period; hold freezes it.
module flash_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt;

    assign tick = !hold && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? 16'd0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/param_flasher.sv
// Three-ramp lamp flasher: level counter driven by a tick-gated FSM, thermometer lamp output.
module param_flasher
    import param_flasher_pkg::*;
#(
    parameter int MX_LP  = 16,
    parameter int KB_1   = 5,
    parameter int PEAK_2 = 10,
    parameter int PEAK_3 = 5,
    parameter int DIV    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    input  logic             hold,
    output logic [MX_LP-1:0] lamp,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done
);

    localparam int LW = clog2(MX_LP + 1);
    localparam logic [LW-1:0] MX_L = LW'(MX_LP);
    localparam logic [LW-1:0] KB_L = LW'(KB_1);
    localparam logic [LW-1:0] PK2_L = LW'(PEAK_2);
    localparam logic [LW-1:0] PK3_L = LW'(PEAK_3);
    localparam logic [LW-1:0] ZERO = '0;

    logic          tick;
    logic [LW-1:0] level;
    logic [LW-1:0] lv_up;
    logic [LW-1:0] lv_dn;
    logic [LW-1:0] lv_nxt;
    logic [2:0]    st_nxt;
    logic          done_nxt;

    flash_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .tick  (tick)
    );

    // Saturating steps keep the level inside 0..MX_LP even from a bad state.
    assign lv_up = (level == MX_L) ? level : level + 1'b1;
    assign lv_dn = (level == ZERO) ? level : level - 1'b1;

    always_comb begin
        st_nxt   = state;
        lv_nxt   = level;
        done_nxt = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (flick) begin
                        lv_nxt = LW'(1);
                        st_nxt = UP1;
                    end else begin
                        lv_nxt = ZERO;
                    end
                end
                UP1: begin
                    lv_nxt = lv_up;
                    if (lv_up == MX_L) st_nxt = DN1;
                end
                DN1: begin
                    lv_nxt = lv_dn;
                    if (lv_dn == KB_L) st_nxt = flick ? UP1 : UP2;
                end
                UP2: begin
                    lv_nxt = lv_up;
                    if (lv_up == PK2_L) st_nxt = DN2;
                end
                DN2: begin
                    lv_nxt = lv_dn;
                    if (lv_dn == KB_L && flick) st_nxt = UP2;
                    else if (lv_dn == ZERO)     st_nxt = flick ? UP2 : UP3;
                end
                UP3: begin
                    lv_nxt = lv_up;
                    if (lv_up == PK3_L) st_nxt = DN3;
                end
                DN3: begin
                    lv_nxt = lv_dn;
                    if (lv_dn == ZERO) begin
                        st_nxt   = IDLE;
                        done_nxt = 1'b1;
                    end
                end
                default: begin
                    st_nxt = IDLE;
                    lv_nxt = ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= ZERO;
            lamp  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= st_nxt;
            level <= lv_nxt;
            busy  <= (st_nxt != IDLE);
            done  <= done_nxt;
            for (int i = 0; i < MX_LP; i++) begin
                lamp[i] <= (LW'(i) < lv_nxt);
            end
        end
    end

endmodule

// File: tb/tb_param_flasher.sv
// Directed bench for param_flasher: default, small-parameter and DIV=4 instances.
module tb_param_flasher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flick = 1'b0;
    logic sel = 1'b0;
    logic flick_d4 = 1'b0;
    logic hold_d4 = 1'b0;

    logic [15:0] lamp_def;
    logic [2:0]  state_def;
    logic        busy_def, done_def;
    logic [7:0]  lamp_sm;
    logic [2:0]  state_sm;
    logic        busy_sm, done_sm;
    logic [15:0] lamp_d4;
    logic [2:0]  state_d4;
    logic        busy_d4, done_d4;

    logic        flick_def, flick_sm;
    logic [63:0] obs_lamp;
    logic [2:0]  obs_state;
    logic        obs_busy, obs_done;

    int n_err = 0;
    int n_chk = 0;

    int exp_lv[$];
    int exp_st[$];
    bit exp_fl[$];

    localparam int S_IDLE = 0, S_UP1 = 1, S_DN1 = 2, S_UP2 = 3, S_DN2 = 4, S_UP3 = 5, S_DN3 = 6;

    always #5 clk = ~clk;

    assign flick_def = flick & ~sel;
    assign flick_sm  = flick & sel;
    assign obs_lamp  = sel ? 64'(lamp_sm) : 64'(lamp_def);
    assign obs_state = sel ? state_sm : state_def;
    assign obs_busy  = sel ? busy_sm : busy_def;
    assign obs_done  = sel ? done_sm : done_def;

    param_flasher u_def (
        .clk(clk), .rst_n(rst_n), .flick(flick_def), .hold(1'b0),
        .lamp(lamp_def), .state(state_def), .busy(busy_def), .done(done_def)
    );

    param_flasher #(.MX_LP(8), .KB_1(2), .PEAK_2(6), .PEAK_3(3)) u_sm (
        .clk(clk), .rst_n(rst_n), .flick(flick_sm), .hold(1'b0),
        .lamp(lamp_sm), .state(state_sm), .busy(busy_sm), .done(done_sm)
    );

    param_flasher #(.DIV(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .flick(flick_d4), .hold(hold_d4),
        .lamp(lamp_d4), .state(state_d4), .busy(busy_d4), .done(done_d4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] thermo(input int lv);
        logic [63:0] one;
        one = 64'd1;
        if (lv >= 64) return '1;
        return (one << lv) - 64'd1;
    endfunction

    // Levels a..b (either direction) in state s, the last one landing in s_end.
    task automatic add_ramp(input int a, input int b, input int s, input int s_end, input bit f_last);
        int stp;
        int lv;
        stp = (b >= a) ? 1 : -1;
        lv = a;
        forever begin
            exp_lv.push_back(lv);
            exp_st.push_back(lv == b ? s_end : s);
            exp_fl.push_back(lv == b ? f_last : 1'b0);
            if (lv == b) break;
            lv += stp;
        end
    endtask

    task automatic run_exp(input string tag, input bit end_done);
        int n;
        n = exp_lv.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            flick = exp_fl[i];
            @(posedge clk);
            #1;
            chk($sformatf("%s_lamp_t%0d", tag, i + 1), obs_lamp, thermo(exp_lv[i]));
            chk($sformatf("%s_state_t%0d", tag, i + 1), 64'(obs_state), 64'(exp_st[i]));
            chk($sformatf("%s_busy_t%0d", tag, i + 1), 64'(obs_busy), 64'(exp_st[i] != S_IDLE));
            chk($sformatf("%s_done_t%0d", tag, i + 1), 64'(obs_done), 64'(end_done && i == n - 1));
        end
        @(negedge clk);
        flick = 1'b0;
        if (end_done) begin
            @(posedge clk);
            #1;
            chk({tag, "_done_clear"}, 64'(obs_done), 64'd0);
            chk({tag, "_idle"}, 64'(obs_state), 64'(S_IDLE));
        end
        exp_lv.delete();
        exp_st.delete();
        exp_fl.delete();
    endtask

    task automatic build_default(input bit f_start);
        add_ramp(1, 1, S_UP1, S_UP1, f_start);
        add_ramp(2, 16, S_UP1, S_DN1, 1'b0);
        add_ramp(15, 5, S_DN1, S_UP2, 1'b0);
        add_ramp(6, 10, S_UP2, S_DN2, 1'b0);
        add_ramp(9, 0, S_DN2, S_UP3, 1'b0);
        add_ramp(1, 5, S_UP3, S_DN3, 1'b0);
        add_ramp(4, 0, S_DN3, S_IDLE, 1'b0);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_lamp", 64'(lamp_def), 64'd0);
        chk("rst_state", 64'(state_def), 64'd0);
        chk("rst_busy", 64'(busy_def), 64'd0);
        chk("rst_done", 64'(done_def), 64'd0);
        chk("rst_sm_lamp", 64'(lamp_sm), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain full sequence: 52 ticks, single done.
        build_default(1'b1);
        run_exp("full", 1'b1);

        // Kickback in DN1 at level 5, plus ignored flicks mid UP1 and off-boundary in DN1.
        add_ramp(1, 1, S_UP1, S_UP1, 1'b1);
        add_ramp(2, 8, S_UP1, S_UP1, 1'b1);
        add_ramp(9, 16, S_UP1, S_DN1, 1'b0);
        add_ramp(15, 9, S_DN1, S_DN1, 1'b1);
        add_ramp(8, 5, S_DN1, S_UP1, 1'b1);
        add_ramp(6, 16, S_UP1, S_DN1, 1'b0);
        add_ramp(15, 5, S_DN1, S_UP2, 1'b0);
        add_ramp(6, 10, S_UP2, S_DN2, 1'b0);
        add_ramp(9, 0, S_DN2, S_UP3, 1'b0);
        add_ramp(1, 5, S_UP3, S_DN3, 1'b0);
        add_ramp(4, 0, S_DN3, S_IDLE, 1'b0);
        run_exp("kb1", 1'b1);

        // DN2 kickback at level 5, then re-entry to UP2 from level 0.
        add_ramp(1, 1, S_UP1, S_UP1, 1'b1);
        add_ramp(2, 16, S_UP1, S_DN1, 1'b0);
        add_ramp(15, 5, S_DN1, S_UP2, 1'b0);
        add_ramp(6, 10, S_UP2, S_DN2, 1'b0);
        add_ramp(9, 5, S_DN2, S_UP2, 1'b1);
        add_ramp(6, 10, S_UP2, S_DN2, 1'b0);
        add_ramp(9, 0, S_DN2, S_UP2, 1'b1);
        add_ramp(1, 10, S_UP2, S_DN2, 1'b0);
        add_ramp(9, 0, S_DN2, S_UP3, 1'b0);
        add_ramp(1, 5, S_UP3, S_DN3, 1'b0);
        add_ramp(4, 0, S_DN3, S_IDLE, 1'b0);
        run_exp("kb2", 1'b1);

        // Small configuration: 8,2,6,0,3,0 in 30 ticks.
        sel = 1'b1;
        add_ramp(1, 1, S_UP1, S_UP1, 1'b1);
        add_ramp(2, 8, S_UP1, S_DN1, 1'b0);
        add_ramp(7, 2, S_DN1, S_UP2, 1'b0);
        add_ramp(3, 6, S_UP2, S_DN2, 1'b0);
        add_ramp(5, 0, S_DN2, S_UP3, 1'b0);
        add_ramp(1, 3, S_UP3, S_DN3, 1'b0);
        add_ramp(2, 0, S_DN3, S_IDLE, 1'b0);
        run_exp("small", 1'b1);
        sel = 1'b0;

        // Abort mid-DN2 at level 4 with reset.
        add_ramp(1, 1, S_UP1, S_UP1, 1'b1);
        add_ramp(2, 16, S_UP1, S_DN1, 1'b0);
        add_ramp(15, 5, S_DN1, S_UP2, 1'b0);
        add_ramp(6, 10, S_UP2, S_DN2, 1'b0);
        add_ramp(9, 4, S_DN2, S_DN2, 1'b0);
        run_exp("pre_abort", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_lamp", 64'(lamp_def), 64'd0);
        chk("abort_state", 64'(state_def), 64'(S_IDLE));
        chk("abort_busy", 64'(busy_def), 64'd0);
        chk("abort_done", 64'(done_def), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(done_def), 64'd0);
        end
        build_default(1'b1);
        run_exp("restart", 1'b1);

        // DIV=4 with a 3-cycle hold right after level 7.
        @(negedge clk);
        rst_n = 1'b0;
        flick_d4 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (k < 400) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) chk("d4_no_tick_yet", 64'(state_d4), 64'(S_IDLE));
            if (k == 4) begin
                chk("d4_first_tick", 64'(lamp_d4), thermo(1));
                flick_d4 = 1'b0;
            end
            if (k == 7) chk("d4_between", 64'(lamp_d4), thermo(1));
            if (k == 8) chk("d4_tick2", 64'(lamp_d4), thermo(2));
            if (k == 28) begin
                chk("d4_lv7", 64'(lamp_d4), thermo(7));
                hold_d4 = 1'b1;
            end
            if (k == 31) begin
                chk("d4_held", 64'(lamp_d4), thermo(7));
                hold_d4 = 1'b0;
            end
            if (k == 34) chk("d4_pre8", 64'(lamp_d4), thermo(7));
            if (k == 35) chk("d4_lv8", 64'(lamp_d4), thermo(8));
            if (k > 4 && k < 211) chk("d4_busy", 64'(busy_d4), 64'd1);
            if (done_d4) break;
        end
        chk("d4_done_clock", 64'(k), 64'd211);
        @(posedge clk);
        #1;
        chk("d4_done_clear", 64'(done_d4), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/param_flasher.md
PARAM_FLASHER -- requirements
Module: param_flasher

Interface
REQ-001 Parameter MX_LP, default 16: number of lamps, legal range 4..64.
REQ-002 Parameter KB_1, default 5: kickback level, legal range 1..PEAK_2-1.
REQ-003 Parameter PEAK_2, default 10: top level of second ramp, legal range KB_1+1..MX_LP.
REQ-004 Parameter PEAK_3, default 5: top level of third ramp, legal range 1..MX_LP.
REQ-005 Parameter DIV, default 1: clocks per step tick, legal range 1..65535.
REQ-006 clk  input  1  single clock; every flop on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 flick  input  1  start/kickback request; sampled only on tick cycles.
REQ-009 hold  input  1  freeze: while 1, divider, level and state do not change.
REQ-010 lamp  output  MX_LP  registered thermometer, lamps [L-1:0] on, where L is the current level.
REQ-011 state  output  3  registered current state code.
REQ-012 busy  output  1  registered, 1 whenever state is not IDLE.
REQ-013 done  output  1  registered one-cycle pulse at sequence completion.

Function
REQ-014 Level L shall be an unsigned counter of width clog2(MX_LP+1); lamp shall equal the thermometer decode of L.
REQ-015 A tick shall occur when hold=0 and the divider count equals DIV-1.
- The divider counts 0..DIV-1 and wraps.
- With DIV=1, every hold=0 cycle is a tick.
REQ-016 Level and state shall change only on tick cycles.
REQ-017 States: IDLE, UP1, DN1, UP2, DN2, UP3, DN3; encoding 0..6 in that order; codes 7 are illegal.
REQ-018 IDLE: tick with flick=1 -> L=1, go to UP1; tick with flick=0 -> stay, L=0.
REQ-019 UP1: each tick L+1; when new L==MX_LP -> DN1.
REQ-020 DN1: each tick L-1; when new L==KB_1, go to UP1 if flick=1 on that tick, else UP2.
REQ-021 UP2: each tick L+1; when new L==PEAK_2 -> DN2.
REQ-022 DN2: each tick L-1 with these checks on the new L:
- new L==KB_1 and flick=1 -> UP2 (kickback).
- new L==0 -> UP2 if flick=1, else UP3.
REQ-023 UP3: each tick L+1; when new L==PEAK_3 -> DN3.
REQ-024 DN3: each tick L-1; when new L==0 -> IDLE, and done=1 for exactly the following cycle.
REQ-025 When a down state's new L equals its boundary and flick=1, the flick branch shall take priority over the default transition.
REQ-026 L shall never exceed MX_LP nor underflow below 0.
REQ-027 Illegal state code: next state shall be IDLE with L=0.
REQ-028 flick asserted in an up state, or in a down state off its boundary level, shall be ignored.

Reset
REQ-029 rst_n=0 shall immediately force: state=IDLE, L=0, lamp=0, busy=0, done=0, divider=0.
REQ-030 Reset asserted mid-sequence shall abort the sequence without a done pulse; operation resumes from IDLE after release.

Structure
REQ-031 A shared package shall hold the state enumeration and the level-width function clog2.
REQ-032 The divider shall be a separate sub-module, flash_tick_gen (ports clk, rst_n, hold, tick).
REQ-033 The top level shall contain the state machine, level counter and thermometer decode.

Verification
REQ-034 Defaults, DIV=1, flick=1 for one cycle from IDLE, hold=0 -> L rises 1..16, falls to 5, rises to 10, falls to 0, rises to 5, falls to 0; done pulses once after 52 ticks; busy=1 throughout.
REQ-035 Defaults, flick=1 on the tick where L reaches 5 in DN1 -> UP1, L=6, climbs to 16 again.
REQ-036 Defaults, flick=1 on the ticks where L reaches 5 and then 0 in DN2 -> each time returns to UP2 (L=6 and L=1 next respectively).
REQ-037 DIV=4, hold pulsed 3 cycles during UP1 at L=7 -> L steps every 4 clocks, holds at 7 for 3 extra cycles; total sequence 52 ticks = 208 clocks + 3.
REQ-038 MX_LP=8, KB_1=2, PEAK_2=6, PEAK_3=3 -> sequence 8,2,6,0,3,0 levels; done after 8+6+4+6+3+3 = 30 ticks.
REQ-039 rst_n=0 asserted mid-DN2 at L=4 -> lamp=0, state=IDLE in the same cycle, no done pulse; a fresh flick restarts from L=1.
